alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//   Decode/issue stage directly upstream of the ALU. Accepts one RV32I instruction per cycle,
//   decodes it to the 5-bit ALU select code, builds op1/op2, and registers them in the ID/EX
//   pipeline register. The registered outputs drive alu.op1/op2/sel; rd/we go to writeback.
//   Covers OP-IMM, OP, LUI and AUIPC. Latency is 1 cycle. Uses a valid/ready handshake on both sides.
// PARAMETERS
//   DWIDTH     32  operand width; only 32 is supported
//   SEL_WIDTH   5  ALU select width
//   ZERO_X0     1  1: force op1/op2 to 0 when rs1/rs2 index is 0, ignoring rs*_data
// PORTS
//   clk        in   1   clock; all state updates on the rising edge
//   rst        in   1   reset; asynchronous, active-high
//   flush      in   1   synchronous kill of the held entry
//   in_valid   in   1   instr/pc/rs*_data valid
//   in_ready   out  1   stage can accept this cycle
//   instr      in   32  RV32I instruction word
//   pc         in   32  PC of instr
//   rs1_data   in   32  RF read data for instr[19:15]
//   rs2_data   in   32  RF read data for instr[24:20]
//   out_valid  out  1   registered ALU request valid
//   out_ready  in   1   downstream accepts the request
//   out_sel    out  5   ALU select code
//   out_op1    out  32  ALU op1
//   out_op2    out  32  ALU op2
//   out_rd     out  5   destination register
//   out_we     out  1   writeback enable
//   out_illegal out 1   present only with ILLEGAL_TRAP_EN
// BEHAVIOUR
// - Reset (async): out_valid=0, out_sel=0, out_op1=0, out_op2=0, out_rd=0, out_we=0, out_illegal=0.
// - in_ready = !flush && (!out_valid || out_ready); the signal is combinational.
// - Accept occurs when in_valid && in_ready. The decoded entry loads and out_valid=1 on the next edge.
// - If there is no accept and out_ready=1, out_valid goes to 0.
// - While out_valid && !out_ready, all out_* hold stable.
// - flush=1: out_valid=0 on the next edge. Nothing is accepted in that cycle.
// - flush takes priority over everything except rst.
// - Select codes: ADDI0 SLTI1 SLTIU2 XORI3 ORI4 ANDI5 SLLI6 SRLI7 SRAI8 ADD9 SUB10 SLL11 SLT12
//   SLTU13 XOR14 SRL15 SRA16 OR17 AND18.
// - OP-IMM (0010011): op1=rs1_data.
//   - op2 = sign-extended imm[11:0].
//   - For shifts, op2 = {27'b0, instr[24:20]} (shamt only).
//   - SRAI is selected by instr[30]=1.
// - OP (0110011): op1=rs1_data, op2=rs2_data.
//   - funct7 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
// - LUI (0110111): sel=ADDI, op1=0, op2={instr[31:12],12'b0}.
// - AUIPC (0010111): sel=ADDI, op1=pc, op2={instr[31:12],12'b0}.
// - out_we = legal && (rd != 0). A write to x0 still issues, with we=0.
// - Illegal: any other opcode.
//   - Also illegal: OP funct7 other than 0000000, or 0100000 as allowed above.
//   - Also illegal: SLLI/SRLI with imm[11:5]!=0000000, or SRAI with imm[11:5]!=0100000.
// - rs*_data are sampled only at the accept edge. Later changes have no effect on a held entry.
// - Simultaneous accept and out_ready (pipelined flow): the new entry replaces the old one. This sustains 1 instr/cycle.
// CONFIGURATION
//   ILLEGAL_TRAP_EN defined:
//     - the out_illegal port exists.
//     - An illegal instruction is accepted and issued with out_valid=1, out_illegal=1, out_we=0, sel=0, op1=op2=0.
//   ILLEGAL_TRAP_EN undefined:
//     - there is no out_illegal port.
//     - An illegal instruction is accepted (in_ready unaffected) and dropped: out_valid=0 on the next edge.
// TESTING
// 1. Issue instr=0xFFE08293 (addi x5,x1,-2) with rs1_data=1.
//    -> Next cycle: out_valid=1, sel=0, op1=1, op2=0xFFFFFFFE, rd=5, we=1.
// 2. Issue 0x41F15193 (srai x3,x2,31), then 0x405303B3 (sub x7,x6,x5) with rs1_data=10, rs2_data=3, back to back.
//    -> First: sel=8, op2=31.
//    -> Second: sel=10, op1=10, op2=3.
//    -> Then out_valid stays 1 across both cycles.
// 3. Issue 0x123450B7 (lui x1,0x12345).
//    -> sel=0, op1=0, op2=0x12345000.
//    Issue 0x00001117 (auipc x2,1) with pc=0x1000.
//    -> op1=0x1000, op2=0x1000.
// 4. Hold out_ready=0 with out_valid=1 and in_valid=1 for 3 cycles.
//    -> in_ready=0 and out_* unchanged.
//    Raise out_ready.
//    -> in_ready=1 and the pending instr appears on the next edge.
// 5. flush=1 while an entry is held.
//    -> out_valid=0 next edge, in_ready=0 during flush.
//    Assert rst mid-transfer.
//    -> All outputs are 0 immediately, without waiting for clk.
// 6. Issue 0x00000003 (load) and 0x02000033 (funct7=0000001).
//    -> With ILLEGAL_TRAP_EN: out_illegal=1, we=0.
//    -> Without ILLEGAL_TRAP_EN: out_valid stays 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage feeding the ALU: decodes OP-IMM, OP, LUI and AUIPC into an ALU request
// held in a valid/ready ID/EX register. Define ILLEGAL_TRAP_EN to issue illegal instructions flagged on out_illegal.
module alu_issue_stage #(
    parameter int DWIDTH    = 32,
    parameter int SEL_WIDTH = 5,
    parameter bit ZERO_X0   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [DWIDTH-1:0]    pc,
    input  logic [DWIDTH-1:0]    rs1_data,
    input  logic [DWIDTH-1:0]    rs2_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_WIDTH-1:0] out_sel,
    output logic [DWIDTH-1:0]    out_op1,
    output logic [DWIDTH-1:0]    out_op2,
    output logic [4:0]           out_rd,
    output logic                 out_we
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                 out_illegal
`endif
);

    typedef enum logic [SEL_WIDTH-1:0] {
        SEL_ADDI  = 5'd0,  SEL_SLTI = 5'd1,  SEL_SLTIU = 5'd2,  SEL_XORI = 5'd3,
        SEL_ORI   = 5'd4,  SEL_ANDI = 5'd5,  SEL_SLLI  = 5'd6,  SEL_SRLI = 5'd7,
        SEL_SRAI  = 5'd8,  SEL_ADD  = 5'd9,  SEL_SUB   = 5'd10, SEL_SLL  = 5'd11,
        SEL_SLT   = 5'd12, SEL_SLTU = 5'd13, SEL_XOR   = 5'd14, SEL_SRL  = 5'd15,
        SEL_SRA   = 5'd16, SEL_OR   = 5'd17, SEL_AND   = 5'd18
    } sel_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [DWIDTH-1:0] rs1_val;
    logic [DWIDTH-1:0] rs2_val;
    logic [DWIDTH-1:0] imm_i;
    logic [DWIDTH-1:0] imm_u;
    logic [DWIDTH-1:0] shamt;

    logic              dec_legal;
    sel_e              dec_sel;
    logic [DWIDTH-1:0] dec_op1;
    logic [DWIDTH-1:0] dec_op2;
    logic              dec_we;
    logic              accept;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rd      = instr[11:7];
    assign rs1_val = (ZERO_X0 && instr[19:15] == 5'd0) ? '0 : rs1_data;
    assign rs2_val = (ZERO_X0 && instr[24:20] == 5'd0) ? '0 : rs2_data;
    assign imm_i   = {{(DWIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_u   = {instr[31:12], 12'b0};
    assign shamt   = {{(DWIDTH-5){1'b0}}, instr[24:20]};

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case tree infers a latch.
        dec_legal = 1'b0;
        dec_sel   = SEL_ADDI;
        dec_op1   = '0;
        dec_op2   = '0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_legal = 1'b1;
                dec_op1   = rs1_val;
                dec_op2   = imm_i;
                case (funct3)
                    3'b000: dec_sel = SEL_ADDI;
                    3'b010: dec_sel = SEL_SLTI;
                    3'b011: dec_sel = SEL_SLTIU;
                    3'b100: dec_sel = SEL_XORI;
                    3'b110: dec_sel = SEL_ORI;
                    3'b111: dec_sel = SEL_ANDI;
                    3'b001: begin
                        dec_sel   = SEL_SLLI;
                        dec_op2   = shamt;
                        dec_legal = (funct7 == F7_ZERO);
                    end
                    default: begin
                        dec_op2 = shamt;
                        if (funct7 == F7_ALT) begin
                            dec_sel = SEL_SRAI;
                        end else begin
                            dec_sel   = SEL_SRLI;
                            dec_legal = (funct7 == F7_ZERO);
                        end
                    end
                endcase
            end
            OPC_OP: begin
                dec_op1 = rs1_val;
                dec_op2 = rs2_val;
                if (funct7 == F7_ZERO) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_sel = SEL_ADD;
                        3'b001:  dec_sel = SEL_SLL;
                        3'b010:  dec_sel = SEL_SLT;
                        3'b011:  dec_sel = SEL_SLTU;
                        3'b100:  dec_sel = SEL_XOR;
                        3'b101:  dec_sel = SEL_SRL;
                        3'b110:  dec_sel = SEL_OR;
                        default: dec_sel = SEL_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                    dec_sel   = (funct3 == 3'b101) ? SEL_SRA : SEL_SUB;
                end
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_op2   = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_op1   = pc;
                dec_op2   = imm_u;
            end
            default: dec_legal = 1'b0;
        endcase
        // An illegal entry is issued (trap build only) as an inert request.
        if (!dec_legal) begin
            dec_sel = SEL_ADDI;
            dec_op1 = '0;
            dec_op2 = '0;
        end
    end

    assign dec_we = dec_legal && (rd != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            out_valid <= 1'b0;
            out_sel   <= '0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_we    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            if (dec_legal || TRAP) begin
                out_valid <= 1'b1;
                out_sel   <= dec_sel;
                out_op1   <= dec_op1;
                out_op2   <= dec_op2;
                out_rd    <= rd;
                out_we    <= dec_we;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_illegal <= 1'b0;
        end else if (!flush && accept) begin
            out_illegal <= !dec_legal;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; expected values are hand-decoded from the
// instruction encodings. Checks for out_illegal are compiled in only with ILLEGAL_TRAP_EN.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_sel;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_we;
`ifdef ILLEGAL_TRAP_EN
    logic        out_illegal;
`endif

    int check_cnt = 0;
    int error_cnt = 0;

    alu_issue_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_rd    (out_rd),
        .out_we    (out_we)
`ifdef ILLEGAL_TRAP_EN
        ,
        .out_illegal (out_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) else begin
            error_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [4:0] sel,
                           input logic [31:0] op1, input logic [31:0] op2,
                           input logic [4:0] rd, input logic we);
        chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({tag, ".sel"},   {27'b0, out_sel},   {27'b0, sel});
        chk({tag, ".op1"},   out_op1, op1);
        chk({tag, ".op2"},   out_op2, op2);
        chk({tag, ".rd"},    {27'b0, out_rd},    {27'b0, rd});
        chk({tag, ".we"},    {31'b0, out_we},    {31'b0, we});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
        #2;
        chk_out("reset", 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        chk("reset.illegal", {31'b0, out_illegal}, 32'h0);
`endif
        step(); step();
        rst = 1'b0;

        // addi x5,x1,-2
        in_valid = 1'b1; out_ready = 1'b1;
        instr = 32'hFFE08293; rs1_data = 32'd1;
        #1 chk("t1.in_ready", {31'b0, in_ready}, 32'h1);
        step();
        chk_out("t1.addi", 1'b1, 5'd0, 32'h1, 32'hFFFFFFFE, 5'd5, 1'b1);

        // srai x3,x2,31 then sub x7,x6,x5 back to back
        instr = 32'h41F15193; rs1_data = 32'h80000000;
        step();
        chk_out("t2.srai", 1'b1, 5'd8, 32'h80000000, 32'd31, 5'd3, 1'b1);
        instr = 32'h405303B3; rs1_data = 32'd10; rs2_data = 32'd3;
        step();
        chk_out("t2.sub", 1'b1, 5'd10, 32'd10, 32'd3, 5'd7, 1'b1);

        // lui x1,0x12345 (rs1 field nonzero, op1 must still be 0)
        instr = 32'h123450B7; rs1_data = 32'hDEADBEEF;
        step();
        chk_out("t3.lui", 1'b1, 5'd0, 32'h0, 32'h12345000, 5'd1, 1'b1);

        // auipc x2,1
        instr = 32'h00001117; pc = 32'h1000;
        step();
        chk_out("t3.auipc", 1'b1, 5'd0, 32'h1000, 32'h1000, 5'd2, 1'b1);

        // stall: xor x3,x1,x2 pending while downstream is not ready
        out_ready = 1'b0;
        instr = 32'h0020C1B3; rs1_data = 32'hF0F0F0F0; rs2_data = 32'h0FF00FF0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4.stall_in_ready", {31'b0, in_ready}, 32'h0);
            step();
            chk_out("t4.stall_hold", 1'b1, 5'd0, 32'h1000, 32'h1000, 5'd2, 1'b1);
        end
        out_ready = 1'b1;
        #1 chk("t4.release_in_ready", {31'b0, in_ready}, 32'h1);
        step();
        chk_out("t4.xor", 1'b1, 5'd14, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd3, 1'b1);

        // held entry ignores later rs*_data changes
        in_valid = 1'b0; out_ready = 1'b0;
        rs1_data = 32'h12345678; rs2_data = 32'h9ABCDEF0;
        step();
        chk_out("t4.sampled", 1'b1, 5'd14, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd3, 1'b1);

        // flush kills held entry and blocks acceptance
        in_valid = 1'b1; instr = 32'hFFE08293; rs1_data = 32'd1; flush = 1'b1;
        #1 chk("t5.flush_in_ready", {31'b0, in_ready}, 32'h0);
        step();
        chk("t5.flush_valid", {31'b0, out_valid}, 32'h0);
        flush = 1'b0; out_ready = 1'b1;

        // add x1,x0,x0: x0 operands forced to zero
        instr = 32'h000000B3; rs1_data = 32'h55555555; rs2_data = 32'hAAAAAAAA;
        step();
        chk_out("t5.add_x0", 1'b1, 5'd9, 32'h0, 32'h0, 5'd1, 1'b1);

        // addi x0,x0,0 issues with we=0; then drain with no input
        instr = 32'h00000013;
        step();
        chk_out("t5.nop", 1'b1, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        in_valid = 1'b0;
        step();
        chk("t5.drain", {31'b0, out_valid}, 32'h0);

        // async reset mid-transfer
        in_valid = 1'b1; instr = 32'hFFE08293; rs1_data = 32'd1;
        step();
        chk("t5.pre_rst_valid", {31'b0, out_valid}, 32'h1);
        #1 rst = 1'b1;
        #1 chk_out("t5.async_rst", 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        step();
        rst = 1'b0;

        // illegal instructions, each preceded by a legal issue
        begin
            logic [31:0] bad [3];
            bad[0] = 32'h00000003; bad[1] = 32'h02000033; bad[2] = 32'h04009093;
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1; instr = 32'hFFE08293; rs1_data = 32'd1;
                step();
                chk("t6.legal_valid", {31'b0, out_valid}, 32'h1);
                instr = bad[i];
                #1 chk("t6.illegal_in_ready", {31'b0, in_ready}, 32'h1);
                step();
`ifdef ILLEGAL_TRAP_EN
                chk_out("t6.trap", 1'b1, 5'd0, 32'h0, 32'h0, out_rd, 1'b0);
                chk("t6.trap_flag", {31'b0, out_illegal}, 32'h1);
`else
                chk("t6.drop_valid", {31'b0, out_valid}, 32'h0);
`endif
            end
        end

        in_valid = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
